// File: rtl/bus_arbiter_if.sv
// Bundle of requester (fetch/data) and shared memory port signals around bus_arbiter.
// Signal suffixes give direction as seen from the arbiter (slave modport).
interface bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              i_req_i;
    logic [ADDR_W-1:0] i_addr_i;
    logic [DATA_W-1:0] i_rdata_o;
    logic              i_ack_o;

    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [3:0]        d_sel_i;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_ack_o;

    logic              err_o;
    logic              stall_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [3:0]        mem_sel_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    modport slave (
        input  i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_sel_i,
        input  mem_rdata_i, mem_ack_i,
        output i_rdata_o, i_ack_o, d_rdata_o, d_ack_o, err_o, stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o
    );

    modport master (
        output i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_sel_i,
        output mem_rdata_i, mem_ack_i,
        input  i_rdata_o, i_ack_o, d_rdata_o, d_ack_o, err_o, stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o
    );
endinterface

// File: rtl/bus_arbiter.sv
// Fetch/data arbiter onto one registered memory port, single outstanding access with timeout.
// Define ARB_RR_EN for round-robin between simultaneous requests; default is data priority.
module bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TO_CYC = 255
) (
    input logic          clk,
    input logic          rst,
    bus_arbiter_if.slave bus
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBusyI = 2'd1;
    localparam logic [1:0] StBusyD = 2'd2;

    localparam logic [7:0] CntLast = 8'(TO_CYC - 1);

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              last_d_q, last_d_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_sel_q, mem_sel_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              i_req_v, d_req_v, grant_d, timeout;
    logic [DATA_W-1:0] rdata_v;

    // A request whose ack is still showing is the one just served, not a new one.
    assign i_req_v = bus.i_req_i & ~i_ack_q;
    assign d_req_v = bus.d_req_i & ~d_ack_q;
    assign timeout = (cnt_q == CntLast);

`ifdef ARB_RR_EN
    assign grant_d = d_req_v & (~i_req_v | ~last_d_q);
`else
    assign grant_d = d_req_v;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d_d    = last_d_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_sel_d   = mem_sel_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        err_d       = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        rdata_v     = '0;
        case (state_q)
            StIdle: begin
                if (grant_d) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we_i;
                    mem_addr_d  = bus.d_addr_i;
                    mem_wdata_d = bus.d_wdata_i;
                    mem_sel_d   = bus.d_sel_i;
                    cnt_d       = 8'd0;
                    last_d_d    = 1'b1;
                    state_d     = StBusyD;
                end else if (i_req_v) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.i_addr_i;
                    mem_wdata_d = '0;
                    mem_sel_d   = 4'hF;
                    cnt_d       = 8'd0;
                    last_d_d    = 1'b0;
                    state_d     = StBusyI;
                end
            end
            StBusyI, StBusyD: begin
                // Ack beats a coinciding timeout; writes and timeouts return zero data.
                if (bus.mem_ack_i || timeout) begin
                    mem_req_d = 1'b0;
                    state_d   = StIdle;
                    err_d     = ~bus.mem_ack_i;
                    rdata_v   = (bus.mem_ack_i && !mem_we_q) ? bus.mem_rdata_i : '0;
                    if (state_q == StBusyD) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = rdata_v;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = rdata_v;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            last_d_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_sel_q   <= 4'h0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_d_q    <= last_d_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_sel_q   <= mem_sel_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            err_q       <= err_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.mem_sel_o   = mem_sel_q;
    assign bus.i_ack_o     = i_ack_q;
    assign bus.d_ack_o     = d_ack_q;
    assign bus.err_o       = err_q;
    assign bus.i_rdata_o   = i_rdata_q;
    assign bus.d_rdata_o   = d_rdata_q;
    assign bus.stall_o     = (bus.i_req_i & ~i_ack_q) | (bus.d_req_i & ~d_ack_q);
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table plus timeout, ack-vs-timeout and reset sequences.
// Expectations for the simultaneous-request vectors follow ARB_RR_EN when it is defined.
module tb_bus_arbiter;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TO_CYC(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dsel;
        logic        mack;
        logic [31:0] mrdata;
        logic        mreq;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [3:0]  msel;
        logic        iack;
        logic        dack;
        logic        err;
        logic [31:0] irdata;
        logic [31:0] drdata;
        logic        stall;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [31:0] ireq, iaddr, dreq, dwe, daddr, dwdata, dsel, mack, mrdata,
        input logic [31:0] mreq, mwe, maddr, mwdata, msel,
        input logic [31:0] iack, dack, err, irdata, drdata, stall);
        vec_t v;
        v.ireq = ireq[0];   v.iaddr = iaddr;   v.dreq = dreq[0];   v.dwe = dwe[0];
        v.daddr = daddr;    v.dwdata = dwdata; v.dsel = dsel[3:0]; v.mack = mack[0];
        v.mrdata = mrdata;  v.mreq = mreq[0];  v.mwe = mwe[0];     v.maddr = maddr;
        v.mwdata = mwdata;  v.msel = msel[3:0];
        v.iack = iack[0];   v.dack = dack[0];  v.err = err[0];
        v.irdata = irdata;  v.drdata = drdata; v.stall = stall[0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.i_req_i     = v.ireq;
        bus.i_addr_i    = v.iaddr;
        bus.d_req_i     = v.dreq;
        bus.d_we_i      = v.dwe;
        bus.d_addr_i    = v.daddr;
        bus.d_wdata_i   = v.dwdata;
        bus.d_sel_i     = v.dsel;
        bus.mem_ack_i   = v.mack;
        bus.mem_rdata_i = v.mrdata;
    endtask

    task automatic check(input int idx, input vec_t v);
        string p;
        p = $sformatf("v%0d", idx);
        vectors++;
        chk1({p, " mem_req"}, bus.mem_req_o, v.mreq);
        if (v.mreq) begin
            chk1({p, " mem_we"}, bus.mem_we_o, v.mwe);
            chk({p, " mem_addr"}, bus.mem_addr_o, v.maddr);
            chk({p, " mem_sel"}, 32'(bus.mem_sel_o), 32'(v.msel));
            if (v.mwe) chk({p, " mem_wdata"}, bus.mem_wdata_o, v.mwdata);
        end
        chk1({p, " i_ack"}, bus.i_ack_o, v.iack);
        chk1({p, " d_ack"}, bus.d_ack_o, v.dack);
        chk1({p, " err"}, bus.err_o, v.err);
        if (v.iack) chk({p, " i_rdata"}, bus.i_rdata_o, v.irdata);
        if (v.dack) chk({p, " d_rdata"}, bus.d_rdata_o, v.drdata);
        chk1({p, " stall"}, bus.stall_o, v.stall);
    endtask

    task automatic idle_inputs();
        vec_t z;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(z);
    endtask

    initial begin
        int k;
        vectors     = 0;
        miscompares = 0;

        // Fetch, ack three cycles after grant, then stray ack in IDLE.
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 'h100, 0, 0, 0, 0, 0, 0, 0,
                             1, 0, 'h100, 0, 'hF, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 'h100, 0, 0, 0, 0, 0, 1, 'h24020005,
                         0, 0, 0, 0, 0, 1, 0, 0, 'h24020005, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 'h9999,
                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Data write; inputs change mid-access and must be ignored.
        tbl.push_back(mk(0, 0, 1, 1, 'h40, 'hDEADBEEF, 'h3, 0, 0,
                         1, 1, 'h40, 'hDEADBEEF, 'h3, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 'h44, 0, 'hF, 0, 0,
                         1, 1, 'h40, 'hDEADBEEF, 'h3, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 'h40, 'hDEADBEEF, 'h3, 1, 'h12345678,
                         0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Data read at minimum latency.
        tbl.push_back(mk(0, 0, 1, 0, 'h80, 0, 'hF, 0, 0,
                         1, 0, 'h80, 0, 'hF, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 'h80, 0, 'hF, 1, 'hCAFEF00D,
                         0, 0, 0, 0, 0, 0, 1, 0, 0, 'hCAFEF00D, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Both requests on one edge; last grant was data.
`ifdef ARB_RR_EN
        tbl.push_back(mk(1, 'h200, 1, 0, 'h300, 0, 'hF, 0, 0,
                         1, 0, 'h200, 0, 'hF, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 'h200, 1, 0, 'h300, 0, 'hF, 1, 'hAAAA0001,
                         0, 0, 0, 0, 0, 1, 0, 0, 'hAAAA0001, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 'h300, 0, 'hF, 0, 0,
                         1, 0, 'h300, 0, 'hF, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 'h300, 0, 'hF, 1, 'hBBBB0002,
                         0, 0, 0, 0, 0, 0, 1, 0, 0, 'hBBBB0002, 0));
`else
        tbl.push_back(mk(1, 'h200, 1, 0, 'h300, 0, 'hF, 0, 0,
                         1, 0, 'h300, 0, 'hF, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 'h200, 1, 0, 'h300, 0, 'hF, 1, 'hAAAA0001,
                         0, 0, 0, 0, 0, 0, 1, 0, 0, 'hAAAA0001, 1));
        tbl.push_back(mk(1, 'h200, 0, 0, 0, 0, 0, 0, 0,
                         1, 0, 'h200, 0, 'hF, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 'h200, 0, 0, 0, 0, 0, 1, 'hBBBB0002,
                         0, 0, 0, 0, 0, 1, 0, 0, 'hBBBB0002, 0, 0));
`endif
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset state.
        rst = 1'b0;
        idle_inputs();
        #3;
        vectors++;
        chk1("rst mem_req", bus.mem_req_o, 1'b0);
        chk1("rst i_ack", bus.i_ack_o, 1'b0);
        chk1("rst d_ack", bus.d_ack_o, 1'b0);
        chk1("rst err", bus.err_o, 1'b0);
        chk1("rst stall", bus.stall_o, 1'b0);
        chk("rst mem_addr", bus.mem_addr_o, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check(i, tbl[i]);
        end

        // Timeout: no ack for TO_CYC busy cycles.
        bus.i_req_i  = 1'b1;
        bus.i_addr_i = 32'h500;
        @(posedge clk);
        #1;
        vectors++;
        chk1("to grant", bus.mem_req_o, 1'b1);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!bus.i_ack_o && k < 300);
        vectors++;
        chk("to cycles", 32'(k), 32'd255);
        chk1("to err", bus.err_o, 1'b1);
        chk("to i_rdata", bus.i_rdata_o, 32'h0);
        chk1("to mem_req", bus.mem_req_o, 1'b0);
        bus.i_req_i = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        chk1("to ack pulse", bus.i_ack_o, 1'b0);
        chk1("to err pulse", bus.err_o, 1'b0);

        // Ack on the same edge the timeout would fire: ack wins.
        bus.d_req_i  = 1'b1;
        bus.d_we_i   = 1'b0;
        bus.d_addr_i = 32'h600;
        bus.d_sel_i  = 4'hF;
        @(posedge clk);
        #1;
        repeat (254) @(posedge clk);
        #1;
        vectors++;
        chk1("race pre ack", bus.d_ack_o, 1'b0);
        chk1("race pre mem_req", bus.mem_req_o, 1'b1);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h55;
        @(posedge clk);
        #1;
        vectors++;
        chk1("race d_ack", bus.d_ack_o, 1'b1);
        chk1("race err", bus.err_o, 1'b0);
        chk("race d_rdata", bus.d_rdata_o, 32'h55);
        idle_inputs();
        @(posedge clk);
        #1;

        // Asynchronous reset during a data access drops it.
        bus.d_req_i   = 1'b1;
        bus.d_we_i    = 1'b1;
        bus.d_addr_i  = 32'h700;
        bus.d_wdata_i = 32'h1;
        bus.d_sel_i   = 4'hF;
        @(posedge clk);
        #1;
        vectors++;
        chk1("rstb grant", bus.mem_req_o, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        chk1("rstb mem_req", bus.mem_req_o, 1'b0);
        chk1("rstb mem_we", bus.mem_we_o, 1'b0);
        chk("rstb mem_addr", bus.mem_addr_o, 32'h0);
        chk("rstb mem_sel", 32'(bus.mem_sel_o), 32'h0);
        chk1("rstb d_ack", bus.d_ack_o, 1'b0);
        chk1("rstb err", bus.err_o, 1'b0);
        bus.d_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.mem_ack_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.mem_ack_i = 1'b0;
            vectors++;
            chk1("rstb no d_ack", bus.d_ack_o, 1'b0);
            chk1("rstb no mem_req", bus.mem_req_o, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
